// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared opcodes, state encodings and helpers for the LCD bus
//            sequencer and its write-strobe generator.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int c_OPCODE_W  = 4;
    localparam int c_OPERAND_W = 12;

    localparam logic [c_OPCODE_W-1:0] c_OP_NOP   = 4'h0;
    localparam logic [c_OPCODE_W-1:0] c_OP_RESET = 4'h9;
    localparam logic [c_OPCODE_W-1:0] c_OP_DELAY = 4'hA;
    localparam logic [c_OPCODE_W-1:0] c_OP_BACK  = 4'hB;
    localparam logic [c_OPCODE_W-1:0] c_OP_CMD   = 4'hC;
    localparam logic [c_OPCODE_W-1:0] c_OP_DATA  = 4'hD;
    localparam logic [c_OPCODE_W-1:0] c_OP_HALT  = 4'hE;
    localparam logic [c_OPCODE_W-1:0] c_OP_FILL  = 4'hF;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_WR_LO   = 4'd3,
        S_WR_HI   = 4'd4,
        S_FB_WAIT = 4'd5,
        S_DELAY   = 4'd6,
        S_RST_LO  = 4'd7,
        S_HALT    = 4'd8
    } seq_state_t;

    // Write-strobe generator phases
    typedef enum logic [1:0] {
        STB_IDLE = 2'd0,
        STB_LOW  = 2'd1,
        STB_HIGH = 2'd2
    } stb_state_t;

    function automatic logic [c_OPCODE_W-1:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

    function automatic logic [c_OPERAND_W-1:0] operand_of(input logic [15:0] instr);
        return instr[11:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_sequencer_if
// Brief    : Control, microprogram ROM, framebuffer and 8080 LCD bus signals
//            of the LCD bus sequencer. master = sequencer side.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_bus_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int PC_WIDTH     = 9,
    parameter int FB_ADR_WIDTH = 16
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [PC_WIDTH-1:0]     instr_adr;
    logic [15:0]             instr_data;
    logic [FB_ADR_WIDTH-1:0] fb_adr;
    logic [DATA_WIDTH-1:0]   fb_data;
    logic [DATA_WIDTH-1:0]   lcd_data;
    logic                    lcd_csx;
    logic                    lcd_dcx;
    logic                    lcd_wrx;
    logic                    lcd_rdx;
    logic                    lcd_resx;

    modport master (
        input  start, instr_data, fb_data,
        output busy, done, instr_adr, fb_adr, lcd_data,
               lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_resx
    );

    modport slave (
        output start, instr_data, fb_data,
        input  busy, done, instr_adr, fb_adr, lcd_data,
               lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_resx
    );
endinterface
`default_nettype wire

// File: rtl/lcd_write_strobe.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_strobe
// Brief    : On a load pulse drives wrx low for WR_LOW cycles, then high for
//            WR_HIGH cycles; flags the last low cycle and the last high cycle.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_strobe
    import lcd_pkg::*;
#(
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic wrx,
    output logic low_last,
    output logic ack,
    output logic busy
);
    localparam int          c_CNT_W     = 16;
    localparam logic [15:0] c_LOW_LAST  = 16'(WR_LOW - 1);
    localparam logic [15:0] c_HIGH_LAST = 16'(WR_HIGH - 1);

    stb_state_t         r_state;
    stb_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // Phase and cycle-count registers; reset parks wrx high at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= STB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Phase sequencing: idle -> low (WR_LOW) -> high (WR_HIGH) -> idle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            STB_IDLE: begin
                if (load) begin
                    w_state_nxt = STB_LOW;
                    w_cnt_nxt   = c_LOW_LAST;
                end
            end
            STB_LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = STB_HIGH;
                    w_cnt_nxt   = c_HIGH_LAST;
                end else begin
                    w_cnt_nxt   = r_cnt - 16'd1;
                end
            end
            STB_HIGH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = STB_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = STB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign wrx      = (r_state != STB_LOW);
    assign low_last = (r_state == STB_LOW)  && (r_cnt == '0);
    assign ack      = (r_state == STB_HIGH) && (r_cnt == '0);
    assign busy     = (r_state != STB_IDLE);

endmodule
`default_nettype wire

// File: rtl/lcd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_sequencer
// Brief    : Microprogrammed 8080-style LCD bus sequencer. Fetches 16-bit
//            instructions from a synchronous ROM and issues command/data
//            writes, framebuffer fills, delays and panel reset pulses.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PC_WIDTH     = 9,
    parameter int FB_ADR_WIDTH = 16,
    parameter int WR_LOW       = 1,
    parameter int WR_HIGH      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    lcd_bus_sequencer_if.master  bus
);
    localparam logic [PC_WIDTH-1:0]     c_PC_ONE = PC_WIDTH'(1);
    localparam logic [FB_ADR_WIDTH-1:0] c_FB_ONE = FB_ADR_WIDTH'(1);
    localparam logic [c_OPERAND_W-1:0]  c_N_ONE  = c_OPERAND_W'(1);

    seq_state_t              r_state,    w_state_nxt;
    logic [PC_WIDTH-1:0]     r_pc,       w_pc_nxt;
    logic [FB_ADR_WIDTH-1:0] r_fb_adr,   w_fb_adr_nxt;
    logic [c_OPERAND_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_lcd_data, w_lcd_data_nxt;
    logic                    r_dcx,      w_dcx_nxt;
    logic                    r_fill,     w_fill_nxt;

    logic                    w_load;
    logic                    w_stb_wrx;
    logic                    w_stb_low_last;
    logic                    w_stb_ack;
    logic                    w_stb_busy;
    logic [c_OPCODE_W-1:0]   w_opcode;
    logic [c_OPERAND_W-1:0]  w_operand;
    logic                    w_busy;

    assign w_opcode  = opcode_of(bus.instr_data);
    assign w_operand = operand_of(bus.instr_data);

    lcd_write_strobe #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_strobe (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .wrx      (w_stb_wrx),
        .low_last (w_stb_low_last),
        .ack      (w_stb_ack),
        .busy     (w_stb_busy)
    );

    // Sequencer state and datapath registers; reset aborts any transaction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_fb_adr   <= '0;
            r_cnt      <= '0;
            r_lcd_data <= '0;
            r_dcx      <= 1'b1;
            r_fill     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_fb_adr   <= w_fb_adr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lcd_data <= w_lcd_data_nxt;
            r_dcx      <= w_dcx_nxt;
            r_fill     <= w_fill_nxt;
        end
    end

    // Next-state: instruction decode and per-state sequencing
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_fb_adr_nxt   = r_fb_adr;
        w_cnt_nxt      = r_cnt;
        w_lcd_data_nxt = r_lcd_data;
        w_dcx_nxt      = r_dcx;
        w_fill_nxt     = r_fill;
        w_load         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_pc_nxt    = r_pc + c_PC_ONE;
                w_state_nxt = S_FETCH;
                case (w_opcode)
                    c_OP_CMD, c_OP_DATA: begin
                        // Hold in DECODE until the strobe has retired its last write
                        if (w_stb_busy) begin
                            w_pc_nxt    = r_pc;
                            w_state_nxt = S_DECODE;
                        end else begin
                            w_pc_nxt       = r_pc;
                            w_lcd_data_nxt = DATA_WIDTH'(bus.instr_data[7:0]);
                            w_dcx_nxt      = (w_opcode == c_OP_DATA);
                            w_fill_nxt     = 1'b0;
                            w_load         = 1'b1;
                            w_state_nxt    = S_WR_LO;
                        end
                    end
                    c_OP_FILL: begin
                        w_fb_adr_nxt = '0;
                        if (w_operand != '0) begin
                            w_pc_nxt    = r_pc;
                            w_cnt_nxt   = w_operand;
                            w_fill_nxt  = 1'b1;
                            w_state_nxt = S_FB_WAIT;
                        end
                    end
                    c_OP_DELAY: begin
                        if (w_operand != '0) begin
                            w_pc_nxt    = r_pc;
                            w_cnt_nxt   = w_operand;
                            w_state_nxt = S_DELAY;
                        end
                    end
                    c_OP_RESET: begin
                        if (w_operand != '0) begin
                            w_pc_nxt    = r_pc;
                            w_cnt_nxt   = w_operand;
                            w_state_nxt = S_RST_LO;
                        end
                    end
                    c_OP_BACK: begin
                        w_pc_nxt = r_pc - PC_WIDTH'(w_operand);
                    end
                    c_OP_HALT: begin
                        w_pc_nxt    = r_pc;
                        w_state_nxt = S_HALT;
                    end
                    default: begin
                        w_pc_nxt = r_pc + c_PC_ONE;
                    end
                endcase
            end
            S_FB_WAIT: begin
                // fb_data now reflects the address presented last cycle
                if (!w_stb_busy) begin
                    w_lcd_data_nxt = bus.fb_data;
                    w_dcx_nxt      = 1'b1;
                    w_load         = 1'b1;
                    w_state_nxt    = S_WR_LO;
                end
            end
            S_WR_LO: begin
                if (w_stb_low_last) begin
                    w_state_nxt = S_WR_HI;
                    // Advance early so the next word is read during WR_HI
                    if (r_fill) begin
                        w_fb_adr_nxt = r_fb_adr + c_FB_ONE;
                    end
                end
            end
            S_WR_HI: begin
                if (w_stb_ack) begin
                    if (r_fill && (r_cnt != c_N_ONE)) begin
                        w_cnt_nxt   = r_cnt - c_N_ONE;
                        w_state_nxt = S_FB_WAIT;
                    end else begin
                        w_fill_nxt  = 1'b0;
                        w_pc_nxt    = r_pc + c_PC_ONE;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DELAY, S_RST_LO: begin
                if (r_cnt == c_N_ONE) begin
                    w_pc_nxt    = r_pc + c_PC_ONE;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_cnt_nxt   = r_cnt - c_N_ONE;
                end
            end
            S_HALT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.busy     = w_busy;
    assign bus.done     = (r_state == S_HALT);
    assign bus.instr_adr = r_pc;
    // Address 0 is presented while a FILL decodes so the first word is ready in FB_WAIT
    assign bus.fb_adr   = ((r_state == S_DECODE) && (w_opcode == c_OP_FILL)) ? '0 : r_fb_adr;
    assign bus.lcd_data = r_lcd_data;
    assign bus.lcd_csx  = ~w_busy;
    assign bus.lcd_dcx  = r_dcx;
    assign bus.lcd_wrx  = w_stb_wrx;
    assign bus.lcd_rdx  = 1'b1;
    assign bus.lcd_resx = (r_state != S_RST_LO);

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_sequencer
// Brief    : Directed bench for lcd_bus_sequencer: two instances (default
//            write timing and WR_LOW=3/WR_HIGH=2) with ROM/framebuffer models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_sequencer;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    lcd_bus_sequencer_if #(.DATA_WIDTH(8), .PC_WIDTH(9), .FB_ADR_WIDTH(16)) bus_a ();
    lcd_bus_sequencer_if #(.DATA_WIDTH(8), .PC_WIDTH(9), .FB_ADR_WIDTH(16)) bus_b ();

    lcd_bus_sequencer #(
        .DATA_WIDTH(8), .PC_WIDTH(9), .FB_ADR_WIDTH(16), .WR_LOW(1), .WR_HIGH(1)
    ) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    lcd_bus_sequencer #(
        .DATA_WIDTH(8), .PC_WIDTH(9), .FB_ADR_WIDTH(16), .WR_LOW(3), .WR_HIGH(2)
    ) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    logic [15:0] rom_a [0:511];
    logic [15:0] rom_b [0:511];

    // History of observed outputs, index 0 = sample just before start
    logic       a_wrx  [0:63];
    logic       a_dcx  [0:63];
    logic [7:0] a_data [0:63];
    logic       a_done [0:63];
    logic       a_busy [0:63];
    logic       a_csx  [0:63];
    logic       a_resx [0:63];
    logic [8:0] a_adr  [0:63];
    logic       b_wrx  [0:63];
    logic       b_dcx  [0:63];
    logic [7:0] b_data [0:63];
    logic       b_done [0:63];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM and framebuffer models (fb word = address + 0x10)
    always @(posedge clock) begin
        bus_a.instr_data <= rom_a[bus_a.instr_adr];
        bus_b.instr_data <= rom_b[bus_b.instr_adr];
        bus_a.fb_data    <= bus_a.fb_adr[7:0] + 8'h10;
        bus_b.fb_data    <= bus_b.fb_adr[7:0] + 8'h10;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_roms();
        for (int i = 0; i < 512; i++) begin
            rom_a[i] = 16'h0000;
            rom_b[i] = 16'h0000;
        end
    endtask

    task automatic record(input int k);
        a_wrx[k]  = bus_a.lcd_wrx;
        a_dcx[k]  = bus_a.lcd_dcx;
        a_data[k] = bus_a.lcd_data;
        a_done[k] = bus_a.done;
        a_busy[k] = bus_a.busy;
        a_csx[k]  = bus_a.lcd_csx;
        a_resx[k] = bus_a.lcd_resx;
        a_adr[k]  = bus_a.instr_adr;
        b_wrx[k]  = bus_b.lcd_wrx;
        b_dcx[k]  = bus_b.lcd_dcx;
        b_data[k] = bus_b.lcd_data;
        b_done[k] = bus_b.done;
    endtask

    // Called at a falling edge; start is high for the next rising edge.
    // restart_k re-pulses start after sample k to probe start-while-busy.
    task automatic run(input int n, input bit go_a, input bit go_b, input int restart_k);
        record(0);
        bus_a.start = go_a;
        bus_b.start = go_b;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            bus_a.start = 1'b0;
            bus_b.start = 1'b0;
            record(k);
            if (k == restart_k) begin
                bus_a.start = go_a;
                bus_b.start = go_b;
            end
        end
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    function automatic int a_writes(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++)
            if (a_wrx[k] == 1'b0 && a_wrx[k-1] == 1'b1) c++;
        return c;
    endfunction

    function automatic logic [8:0] a_write(input int idx, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) begin
            if (a_wrx[k] == 1'b0 && a_wrx[k-1] == 1'b1) begin
                if (c == idx) return {a_dcx[k], a_data[k]};
                c++;
            end
        end
        return 9'h1FF;
    endfunction

    function automatic int a_low_cycles(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (a_wrx[k] == 1'b0) c++;
        return c;
    endfunction

    function automatic int a_done_count(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (a_done[k] == 1'b1) c++;
        return c;
    endfunction

    function automatic int a_done_at(input int n);
        for (int k = 1; k <= n; k++) if (a_done[k] == 1'b1) return k;
        return -1;
    endfunction

    function automatic int a_resx_low(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (a_resx[k] == 1'b0) c++;
        return c;
    endfunction

    function automatic int a_resx_first(input int n);
        for (int k = 1; k <= n; k++) if (a_resx[k] == 1'b0) return k;
        return -1;
    endfunction

    initial begin
        reset       = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        clear_roms();
        @(negedge clock);
        @(negedge clock);

        // Reset state
        check("rst_busy",  32'(bus_a.busy),      32'd0);
        check("rst_done",  32'(bus_a.done),      32'd0);
        check("rst_csx",   32'(bus_a.lcd_csx),   32'd1);
        check("rst_dcx",   32'(bus_a.lcd_dcx),   32'd1);
        check("rst_wrx",   32'(bus_a.lcd_wrx),   32'd1);
        check("rst_rdx",   32'(bus_a.lcd_rdx),   32'd1);
        check("rst_resx",  32'(bus_a.lcd_resx),  32'd1);
        check("rst_data",  32'(bus_a.lcd_data),  32'd0);
        check("rst_iadr",  32'(bus_a.instr_adr), 32'd0);
        check("rst_fbadr", 32'(bus_a.fb_adr),    32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Command then data write, start re-pulsed while busy
        rom_a[0] = 16'hC02A; rom_a[1] = 16'hD055; rom_a[2] = 16'hE000;
        run(14, 1'b1, 1'b0, 6);
        check("p1_busy_k1",   32'(a_busy[1]),       32'd1);
        check("p1_csx_k5",    32'(a_csx[5]),        32'd0);
        check("p1_writes",    32'(a_writes(14)),    32'd2);
        check("p1_write0",    32'(a_write(0, 14)),  32'h02A);
        check("p1_write1",    32'(a_write(1, 14)),  32'h155);
        check("p1_lowcyc",    32'(a_low_cycles(14)), 32'd2);
        check("p1_done_at",   32'(a_done_at(14)),   32'd11);
        check("p1_done_cnt",  32'(a_done_count(14)), 32'd1);
        check("p1_busy_done", 32'(a_busy[11]),      32'd0);
        check("p1_csx_done",  32'(a_csx[11]),       32'd1);
        check("p1_busy_after", 32'(a_busy[12]),     32'd0);
        check("p1_rdx",       32'(bus_a.lcd_rdx),   32'd1);

        // Framebuffer fill of 4 words
        clear_roms();
        rom_a[0] = 16'hF004; rom_a[1] = 16'hE000;
        run(20, 1'b1, 1'b0, 0);
        check("f4_writes", 32'(a_writes(20)),   32'd4);
        check("f4_word0",  32'(a_write(0, 20)), 32'h110);
        check("f4_word1",  32'(a_write(1, 20)), 32'h111);
        check("f4_word2",  32'(a_write(2, 20)), 32'h112);
        check("f4_word3",  32'(a_write(3, 20)), 32'h113);
        check("f4_done_at", 32'(a_done_at(20)), 32'd17);
        check("f4_fbadr",  32'(bus_a.fb_adr),   32'd4);

        // Fill of zero words
        rom_a[0] = 16'hF000;
        run(8, 1'b1, 1'b0, 0);
        check("f0_writes",  32'(a_writes(8)),  32'd0);
        check("f0_done_at", 32'(a_done_at(8)), 32'd5);
        check("f0_fbadr",   32'(bus_a.fb_adr), 32'd0);

        // Panel reset pulse then delay
        clear_roms();
        rom_a[0] = 16'h9003; rom_a[1] = 16'hA005; rom_a[2] = 16'hE000;
        run(18, 1'b1, 1'b0, 0);
        check("rd_resx_low",   32'(a_resx_low(18)),   32'd3);
        check("rd_resx_first", 32'(a_resx_first(18)), 32'd3);
        check("rd_done_at",    32'(a_done_at(18)),    32'd15);
        check("rd_writes",     32'(a_writes(18)),     32'd0);

        // Zero-length reset pulse and delay
        rom_a[0] = 16'h9000; rom_a[1] = 16'hA000;
        run(10, 1'b1, 1'b0, 0);
        check("rd0_resx_low", 32'(a_resx_low(10)), 32'd0);
        check("rd0_done_at",  32'(a_done_at(10)),  32'd7);

        // BACK 1 at pc 0 wraps to 511; start while busy ignored
        clear_roms();
        rom_a[0] = 16'hB001; rom_a[511] = 16'hE000;
        run(8, 1'b1, 1'b0, 2);
        check("wrap_adr_k3",  32'(a_adr[3]),        32'd511);
        check("wrap_done_at", 32'(a_done_at(8)),    32'd5);
        check("wrap_done_cnt", 32'(a_done_count(8)), 32'd1);

        // Stretched strobe on the second instance
        rom_b[0] = 16'hD0FF; rom_b[1] = 16'hE000;
        run(12, 1'b0, 1'b1, 0);
        check("b_wrx_k2", 32'(b_wrx[2]), 32'd1);
        for (int k = 3; k <= 7; k++) begin
            check($sformatf("b_wrx_k%0d", k),  32'(b_wrx[k]),  (k <= 5) ? 32'd0 : 32'd1);
            check($sformatf("b_data_k%0d", k), 32'(b_data[k]), 32'hFF);
            check($sformatf("b_dcx_k%0d", k),  32'(b_dcx[k]),  32'd1);
        end
        check("b_wrx_k8",   32'(b_wrx[8]),   32'd1);
        check("b_done_k10", 32'(b_done[10]), 32'd1);

        // Reset asserted during WR_LO of a looping program
        clear_roms();
        rom_a[0] = 16'hD001; rom_a[1] = 16'hB001;
        run(3, 1'b1, 1'b0, 0);
        check("mr_wrx_lo", 32'(a_wrx[3]), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("mr_wrx",  32'(bus_a.lcd_wrx),  32'd1);
        check("mr_csx",  32'(bus_a.lcd_csx),  32'd1);
        check("mr_busy", 32'(bus_a.busy),     32'd0);
        check("mr_dcx",  32'(bus_a.lcd_dcx),  32'd1);
        check("mr_data", 32'(bus_a.lcd_data), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run(6, 1'b0, 1'b0, 0);
        check("mr_writes_after", 32'(a_writes(6)), 32'd0);
        check("mr_busy_after",   32'(a_busy[6]),   32'd0);
        check("mr_iadr_after",   32'(a_adr[6]),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_bus_sequencer.md
LCD_BUS_SEQUENCER -- requirements
Module: lcd_bus_sequencer

Interface
REQ-001 DATA_WIDTH, default 8, meaning LCD bus width and framebuffer word width (8 or 16).
REQ-002 PC_WIDTH, default 9, meaning microprogram address width.
REQ-003 FB_ADR_WIDTH, default 16, meaning framebuffer address width.
REQ-004 WR_LOW, default 1, meaning wrx low cycles per write (>=1).
REQ-005 WR_HIGH, default 1, meaning wrx high cycles after each write (>=1).
REQ-006 clock  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; starts program at address 0 when idle.
REQ-009 busy  out  1  high from cycle after accepted start until halt.
REQ-010 done  out  1  one-cycle pulse on halt.
REQ-011 instr_adr  out  PC_WIDTH  microprogram address.
REQ-012 instr_data  in  16  microprogram word, valid 1 cycle after instr_adr (synchronous ROM).
REQ-013 fb_adr  out  FB_ADR_WIDTH  framebuffer word address.
REQ-014 fb_data  in  DATA_WIDTH  framebuffer word, valid 1 cycle after fb_adr.
REQ-015 lcd_data  out  DATA_WIDTH  parallel bus data.
REQ-016 lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_resx  out  1 each  8080-style strobes, active-low.

Function
REQ-017 Opcode is instr_data[15:12], operand N is [11:0]: 0=NOP, 9=RESET pulse N cycles, A=DELAY N cycles, B=BACK N, C=COMMAND, D=DATA, E=HALT, F=FILL N words; other opcodes execute as NOP.
REQ-018 States: IDLE, FETCH, DECODE, WR_LO, WR_HI, FB_WAIT, DELAY, RST_LO, HALT.
REQ-019 IDLE: start -> pc=0, FETCH; start while busy ignored.
REQ-020 FETCH drives instr_adr=pc for one cycle; DECODE samples instr_data next cycle.
REQ-021 COMMAND/DATA: lcd_data = zero-extended [7:0], lcd_dcx=0/1, then WR_LO (wrx low WR_LOW cycles), WR_HI (wrx high WR_HIGH cycles), pc+1, FETCH.
REQ-022 lcd_data and lcd_dcx stable from first WR_LO cycle through last WR_HI cycle.
REQ-023 FILL N: fb_adr starts at 0; per word FB_WAIT one cycle, latch fb_data to lcd_data, dcx=1, WR_LO, WR_HI, fb_adr+1; exactly N writes; N=0 -> no writes, pc+1.
REQ-024 fb_adr wraps modulo 2^FB_ADR_WIDTH.
REQ-025 BACK N: pc = pc - N modulo 2^PC_WIDTH, then FETCH; N=0 is a tight loop, legal.
REQ-026 DELAY N: N idle cycles then pc+1; N=0 -> zero extra cycles.
REQ-027 RESET N: lcd_resx low for exactly N cycles (N=0 -> none), then pc+1.
REQ-028 HALT: done high one cycle, busy low same cycle, lcd_csx high, return IDLE.
REQ-029 lcd_csx low while busy, high otherwise; lcd_rdx always high.
REQ-030 pc increment wraps modulo 2^PC_WIDTH.

Reset
REQ-031 Reset asserted: state=IDLE, pc=0, fb_adr=0, instr_adr=0, lcd_data=0, busy=0, done=0, all lcd strobes high, immediately and asynchronously.
REQ-032 Reset mid-write aborts transaction; wrx returns high same instant; no resumption.

Structure
REQ-033 Shared package lcd_pkg holds opcode constants, state enumeration, operand width 12.
REQ-034 One sub-module lcd_write_strobe: load pulse -> WR_LOW/WR_HIGH timed wrx, busy/ack.

Verification
REQ-035 Program C02A,D055,E000; start -> two writes: dcx=0 data 0x2A, dcx=1 data 0x55; wrx low 1 cycle each; done once.
REQ-036 F004 with fb_data=address+0x10 -> lcd_data 0x10,0x11,0x12,0x13 with dcx=1; fb_adr ends 4; F000 -> no writes.
REQ-037 9003,A005,E000 -> resx low exactly 3 cycles, then 5 idle cycles, then done.
REQ-038 WR_LOW=3, WR_HIGH=2, D0FF -> wrx low 3 cycles, high 2, data 0xFF stable all 5.
REQ-039 D001,B001 looping; reset asserted during WR_LO -> all strobes high immediately, state IDLE, busy 0.
REQ-040 Program at pc=0 with B001 -> pc wraps to 2^PC_WIDTH-1; start during busy -> ignored.
